// File: rtl/gba_timer_bank_pkg.sv
// gba_timer_bank_pkg: shared control-field positions and prescaler encoding for the timer bank
package gba_timer_bank_pkg;

    typedef enum logic [1:0] {PRE_1, PRE_64, PRE_256, PRE_1024} prescale_e;

    localparam int CTRL_CASC = 2;
    localparam int CTRL_IRQ  = 6;
    localparam int CTRL_EN   = 7;
    localparam logic [15:0] CTRL_MASK = 16'h00C7;

    localparam int DIV_64   = 64;
    localparam int DIV_256  = 256;
    localparam int DIV_1024 = 1024;

    // terminal prescale count (divide minus one) for an encoding
    function automatic logic [9:0] pre_max(prescale_e p);
        return p == PRE_64   ? 10'(DIV_64 - 1)   :
               p == PRE_256  ? 10'(DIV_256 - 1)  :
               p == PRE_1024 ? 10'(DIV_1024 - 1) : 10'd0;
    endfunction

endpackage

// File: rtl/gba_timer_bank_if.sv
// gba_timer_bank_if: I/O register bus plus per-channel overflow/irq pulses
interface gba_timer_bank_if #(parameter int N_TIMERS = 4);
    logic [11:0]         addr;
    logic [31:0]         data_in;
    logic                write;
    logic [1:0]          width;
    logic [31:0]         data_out;
    logic [N_TIMERS-1:0] overflow;
    logic [N_TIMERS-1:0] irq;

    modport master (output addr, data_in, write, width, input data_out, overflow, irq);
    modport slave  (input addr, data_in, write, width, output data_out, overflow, irq);
endinterface

// File: rtl/gba_timer_channel.sv
// gba_timer_channel: one 16-bit timer with reload, control, prescaler and cascade input
module gba_timer_channel
    import gba_timer_bank_pkg::*;
#(
    parameter bit CASC_OK = 1'b1
) (
    input  logic        clk_mem,
    input  logic        rst,
    input  logic        base_tick,
    input  logic        cascade_in,
    input  logic        wr,
    input  logic [31:0] wr_data,
    input  logic [31:0] wr_mask,
    output logic [31:0] rd_word,
    output logic        ovf,
    output logic        overflow,
    output logic        irq
);

    logic [15:0] count, reload, ctrl, new_reload, new_ctrl;
    logic [9:0]  pre_cnt;
    logic        en, casc, pre_hit, inc, en_rise, pre_chg;

    // merged write values, increment decision and the combinational overflow that feeds the next channel
    always_comb begin
        new_reload = (reload & ~wr_mask[15:0]) | (wr_data[15:0] & wr_mask[15:0]);
        new_ctrl   = ((ctrl & ~wr_mask[31:16]) | (wr_data[31:16] & wr_mask[31:16])) & CTRL_MASK;
        en         = ctrl[CTRL_EN];
        casc       = CASC_OK && ctrl[CTRL_CASC];
        pre_hit    = base_tick && pre_cnt == pre_max(prescale_e'(ctrl[1:0]));
        inc        = en && (casc ? cascade_in : pre_hit);
        ovf        = inc && count == 16'hFFFF;
        en_rise    = wr && !en && new_ctrl[CTRL_EN];
        pre_chg    = wr && new_ctrl[1:0] != ctrl[1:0];
        rd_word    = {ctrl, count};
    end

    // registers: writes, counting with reload on wrap, prescaler, registered pulses
    always_ff @(posedge clk_mem) begin
        if (rst) begin
            count    <= '0;
            reload   <= '0;
            ctrl     <= '0;
            pre_cnt  <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr) begin
                reload <= new_reload;
                ctrl   <= new_ctrl;
            end
            if (en_rise)
                count <= new_reload;
            else if (inc)
                count <= ovf ? reload : count + 1'b1;
            if (en_rise || pre_chg)
                pre_cnt <= '0;
            else if (en && !casc && base_tick)
                pre_cnt <= pre_hit ? '0 : pre_cnt + 1'b1;
            overflow <= ovf;
            irq      <= ovf && ctrl[CTRL_IRQ];
        end
    end

endmodule

// File: rtl/gba_timer_bank.sv
// gba_timer_bank: shared tick divider, register decode, read mux and cascade wiring for N timers
module gba_timer_bank
    import gba_timer_bank_pkg::*;
#(
    parameter int          N_TIMERS  = 4,
    parameter int          TICK_DIV  = 3,
    parameter logic [11:0] BASE_ADDR = 12'h100
) (
    input logic             clk_mem,
    input logic             rst,
    gba_timer_bank_if.slave bus
);

    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]       tick_cnt;
    logic                base_tick;
    logic [4:0]          sh;
    logic [31:0]         wr_mask, wr_data, rd_sel;
    logic [N_TIMERS-1:0] hit, ovf, ovf_q, irq_q;
    logic [31:0]         words [N_TIMERS];

    // byte-lane alignment of writes and the shifted read of the addressed word
    always_comb begin
        sh        = {bus.addr[1:0], 3'b000};
        base_tick = tick_cnt == TW'(TICK_DIV - 1);
        wr_mask   = (bus.width == 2'b00 ? 32'h0000_00FF :
                     bus.width == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
        wr_data   = bus.data_in << sh;
        rd_sel    = '0;
        for (int i = 0; i < N_TIMERS; i++)
            if (hit[i]) rd_sel = words[i];
        bus.data_out = rd_sel >> sh;
    end

    // free-running base tick divider
    always_ff @(posedge clk_mem) begin
        tick_cnt <= (rst || base_tick) ? '0 : tick_cnt + 1'b1;
    end

    assign bus.overflow = ovf_q;
    assign bus.irq      = irq_q;

    for (genvar g = 0; g < N_TIMERS; g++) begin : ch
        logic casc_in;
        assign hit[g] = bus.addr[11:2] == 10'((BASE_ADDR >> 2) + g);
        if (g == 0) begin : first
            assign casc_in = 1'b0;
        end else begin : chained
            assign casc_in = ovf[g-1];
        end
        gba_timer_channel #(.CASC_OK(g > 0)) u_ch (
            .clk_mem    (clk_mem),
            .rst        (rst),
            .base_tick  (base_tick),
            .cascade_in (casc_in),
            .wr         (bus.write && hit[g]),
            .wr_data    (wr_data),
            .wr_mask    (wr_mask),
            .rd_word    (words[g]),
            .ovf        (ovf[g]),
            .overflow   (ovf_q[g]),
            .irq        (irq_q[g])
        );
    end

endmodule

// File: doc/gba_timer_bank.md
GBA_TIMER_BANK -- requirements
Module: gba_timer_bank

Interface
REQ-001 Parameter N_TIMERS, default 4, number of timer channels (1..4).
REQ-002 Parameter TICK_DIV, default 3, clk_mem cycles per base timer tick (50 MHz / 3 ~ 16.67 MHz).
REQ-003 Parameter BASE_ADDR, default 12'h100, I/O offset of timer 0; timer i at BASE_ADDR + 4*i.
REQ-004 clk_mem  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 addr  in  12  I/O register byte offset.
REQ-007 data_in  in  32  write data, right-aligned to addr[1:0].
REQ-008 write  in  1  write strobe, one access per cycle.
REQ-009 width  in  2  00 byte, 01 halfword, 1x word.
REQ-010 data_out  out  32  read data = selected word >> (8*addr[1:0]); 0 for unmapped addr.
REQ-011 overflow  out  N_TIMERS  one-cycle pulse per channel overflow.
REQ-012 irq  out  N_TIMERS  one-cycle pulse on overflow when channel IRQ-enable set.

Function
REQ-013 Per-channel word: [15:0] read = live counter, write = reload value; [31:16] = control (reads back last written value, unused bits 0).
REQ-014 Control bits: [1:0] prescaler 1/64/256/1024 base ticks; [2] cascade; [6] IRQ enable; [7] enable.
REQ-015 Writes merge via mask (0xFF/0xFFFF/0xFFFFFFFF << 8*addr[1:0]); unmasked bytes unchanged.
REQ-016 Shared tick divider: base_tick asserted one clk_mem cycle in every TICK_DIV; free-running, unaffected by writes.
REQ-017 Non-cascade enabled channel: 10-bit prescale counter advances on base_tick; counter increments when prescale count reaches (div-1), then prescale count returns to 0.
REQ-018 Cascade channel (i>0, bit2=1): increments on cycle channel i-1 overflows; prescaler ignored; cascade bit ignored for channel 0.
REQ-019 Overflow: increment from 16'hFFFF loads reload value (not 0), asserts overflow[i] that cycle's next edge for one cycle.
REQ-020 Cascade chain resolves in same cycle: 0 overflow may increment 1, and 1's overflow may increment 2, all on one edge.
REQ-021 Enable 0->1 write: counter <= reload (new reload if same write), prescale count <= 0, no increment that cycle.
REQ-022 Enable 1->0: counter frozen, readable; prescale count held.
REQ-023 Write to reload while running: counter unaffected until next overflow or enable edge.
REQ-024 Write and increment same cycle, enable already 1 and unchanged: increment proceeds; control update takes effect next cycle.
REQ-025 Prescaler change while running: prescale count <= 0.
REQ-026 Reads combinational, zero latency; reading has no side effects.

Reset
REQ-027 rst: counters, reloads, controls, prescale counts, tick divider = 0; overflow, irq = 0 on the following cycle.
REQ-028 rst mid-count or mid-cascade: all state cleared that edge; no overflow/irq pulse generated from the cleared cycle.

Structure
REQ-029 Shared package holds control-bit field positions, prescaler encoding and per-encoding divide constants (64/256/1024).
REQ-030 One sub-module gba_timer_channel (counter, reload, control, prescaler), instantiated N_TIMERS times via generate; bank holds divider, decode, read mux and cascade wiring.

Verification
REQ-031 reload=16'hFFFE, ctrl=0x0080 (div1) -> counter FFFE, FFFF, then FFFE after overflow; overflow[0] pulses once; irq[0] stays 0.
REQ-032 ch0 reload FFFF div1 enabled, ch1 ctrl=0x0084 reload 0 -> ch1 increments once per ch0 overflow (every 3 clk_mem); ch0 at FFFF + ch1 at FFFF wrap same edge.
REQ-033 ctrl=0x00C1 (div64, IRQ) reload FFFF -> first overflow exactly 64*TICK_DIV clk_mem after enable; irq[0] one-cycle pulse.
REQ-034 Byte write 0xAB to BASE_ADDR+1 on word 0x0000_1234 -> reload 0xAB34, control unchanged; byte read at +3 returns control[15:8].
REQ-035 rst asserted one cycle before overflow of running cascade chain -> all counters 0, no overflow/irq pulses; unmapped addr reads 0.
